dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 64-byte data memory. It shares the memory's single access port between port 0 (the CPU load/store path) and port 1 (the debug/DMA loader). Each access is sequenced as a fixed three-state transaction, and memory control signals are driven from registers so that MemWrite is glitch-free. The block sits between the requesters and the data memory and is the only driver of the memory's MemWrite, MemRead, Mem_Addr and Write_Data.

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arb_if.sv | 28 ++
 rtl/dmem_arb_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Used by every file of the block; see dmem_arb_pick for the DMEM_ARB_RR_EN selector.
package dmem_arb_pkg;

   localparam int NPORTS = 2;
   localparam int AW     = 64;
   localparam int DW     = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef logic [$clog2(NPORTS)-1:0] port_idx_t;

   function automatic port_idx_t next_port(input port_idx_t p);
      if (p == port_idx_t'(NPORTS - 1)) begin
         next_port = '0;
      end else begin
         next_port = p + port_idx_t'(1'b1);
      end
   endfunction

   function automatic logic [NPORTS-1:0] port_onehot(input port_idx_t p);
      port_onehot    = '0;
      port_onehot[p] = 1'b1;
   endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface dmem_arb_if;
   import dmem_arb_pkg::*;

   logic [NPORTS-1:0]         req;
   logic [NPORTS-1:0]         we;
   logic [NPORTS-1:0][AW-1:0] addr;
   logic [NPORTS-1:0][DW-1:0] wdata;
   logic [NPORTS-1:0]         ack;
   logic [DW-1:0]             rdata;
   logic                      mem_write;
   logic                      mem_read;
   logic [AW-1:0]             mem_addr;
   logic [DW-1:0]             mem_wdata;
   logic [DW-1:0]             mem_rdata;

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  ack, rdata, mem_write, mem_read, mem_addr, mem_wdata
   );

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output ack, rdata, mem_write, mem_read, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select. DMEM_ARB_RR_EN defined: round-robin from ptr;
// undefined: fixed priority, port 0 wins every tie and ptr is ignored.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req,
   input  port_idx_t         ptr,
   output logic              grant_valid,
   output port_idx_t         grant_id
);

   // Pick one pending requester; grant_id is don't-care when nothing is pending.
   always_comb begin
      grant_valid = |req;
      grant_id    = '0;
`ifdef DMEM_ARB_RR_EN
      if (req[ptr]) begin
         grant_id = ptr;
      end else begin
         grant_id = next_port(ptr);
      end
`else
      if (req[0]) begin
         grant_id = '0;
      end else begin
         grant_id = port_idx_t'(1'b1);
      end
`endif
   end

`ifndef DMEM_ARB_RR_EN
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 64-byte data memory: IDLE -> ACCESS -> RESP.
// All memory controls are registered. DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_arbiter
   import dmem_arb_pkg::*;
(
   input logic       clk,
   input logic       reset,
   dmem_arb_if.slave bus
);

   state_t            state_r;
   state_t            state_s;
   port_idx_t         ptr_s;
   port_idx_t         grant_id_s;
   port_idx_t         grant_id_r;
   logic              grant_valid_s;
   logic [NPORTS-1:0] ack_r;
   logic [DW-1:0]     rdata_r;
   logic              mem_write_r;
   logic              mem_read_r;
   logic [AW-1:0]     mem_addr_r;
   logic [DW-1:0]     mem_wdata_r;

   dmem_arb_pick u_pick (
      .req         (bus.req),
      .ptr         (ptr_s),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

`ifdef DMEM_ARB_RR_EN
   port_idx_t ptr_r;

   // Round-robin pointer moves past the winner on every grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r <= '0;
      end else if ((state_r == IDLE) && grant_valid_s) begin
         ptr_r <= next_port(grant_id_s);
      end
   end

   assign ptr_s = ptr_r;
`else
   assign ptr_s = '0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state: requests are only looked at in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               state_s = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS:  state_s = RESP;
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output registers; strobes and ack are single-cycle, address/data hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_id_r  <= '0;
         ack_r       <= '0;
         rdata_r     <= '0;
         mem_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         ack_r       <= '0;
         mem_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  grant_id_r  <= grant_id_s;
                  mem_addr_r  <= bus.addr[grant_id_s];
                  mem_wdata_r <= bus.wdata[grant_id_s];
                  mem_write_r <= bus.we[grant_id_s];
                  mem_read_r  <= ~bus.we[grant_id_s];
               end
            end
            ACCESS: begin
               ack_r <= port_onehot(grant_id_r);
               if (mem_read_r) begin
                  rdata_r <= bus.mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ack       = ack_r;
   assign bus.rdata     = rdata_r;
   assign bus.mem_write = mem_write_r;
   assign bus.mem_read  = mem_read_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-wide 64-entry memory (byte i resets to i+1),
// a transaction-level reference model checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;

   dmem_arb_if bus ();

   dmem_arbiter dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Environment memory seen by the DUT: combinational little-endian read, wraps modulo 64.
   logic [7:0] env_mem [64];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) env_mem[k] <= 8'(k + 1);
      end else if (bus.mem_write) begin
         for (int k = 0; k < 8; k++)
            env_mem[6'(bus.mem_addr[5:0] + 6'(k))] <= bus.mem_wdata[8*k +: 8];
      end
   end

   always_comb begin
      bus.mem_rdata = '0;
      for (int k = 0; k < 8; k++)
         bus.mem_rdata[8*k +: 8] = env_mem[6'(bus.mem_addr[5:0] + 6'(k))];
   end

   // Reference model: each transaction granted at edge g strobes after g, acks after g+1,
   // and the arbiter is free to grant again at edge g+3.
   int unsigned edge_n = 0;
   logic        t_valid;
   int unsigned t_edge;
   int          t_port;
   logic        t_we;
   logic [63:0] t_addr, t_wdata, t_rdata, prev_rdata;
   int          last_gnt;
   logic [7:0]  ref_mem [64];
   int          m_win;

   function automatic logic [63:0] ref_word(input logic [63:0] a);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[6'(a[5:0] + 6'(k))];
      return w;
   endfunction

   always @(posedge clk) edge_n <= edge_n + 1;

   always_comb begin
      m_win = 0;
`ifdef DMEM_ARB_RR_EN
      if (bus.req == 2'b11) m_win = 1 - last_gnt;
      else if (bus.req[1]) m_win = 1;
      else m_win = 0;
`else
      if (bus.req[0]) m_win = 0;
      else m_win = 1;
`endif
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_valid    <= 1'b0;
         t_edge     <= 0;
         t_port     <= 0;
         t_we       <= 1'b0;
         t_addr     <= '0;
         t_wdata    <= '0;
         t_rdata    <= '0;
         prev_rdata <= '0;
         last_gnt   <= 1;
         for (int k = 0; k < 64; k++) ref_mem[k] <= 8'(k + 1);
      end else begin
         if (t_valid && t_we && (edge_n == t_edge + 1))
            for (int k = 0; k < 8; k++) ref_mem[6'(t_addr[5:0] + 6'(k))] <= t_wdata[8*k +: 8];
         if ((!t_valid || (edge_n >= t_edge + 3)) && (|bus.req)) begin
            t_valid    <= 1'b1;
            t_edge     <= edge_n;
            t_port     <= m_win;
            t_we       <= bus.we[m_win];
            t_addr     <= bus.addr[m_win];
            t_wdata    <= bus.wdata[m_win];
            t_rdata    <= bus.we[m_win] ? (t_valid ? t_rdata : prev_rdata) : ref_word(bus.addr[m_win]);
            prev_rdata <= t_valid ? t_rdata : prev_rdata;
            last_gnt   <= m_win;
         end
      end
   end

   logic [1:0]  x_ack;
   logic        x_wr, x_rd;
   logic [63:0] x_rdata;
   int          off;

   always_comb begin
      off     = int'(edge_n) - 1 - int'(t_edge);
      x_ack   = 2'b00;
      x_wr    = 1'b0;
      x_rd    = 1'b0;
      x_rdata = prev_rdata;
      if (t_valid) begin
         if (off == 0) begin
            x_wr = t_we;
            x_rd = !t_we;
         end
         if (off == 1) x_ack[t_port] = 1'b1;
         if (off >= 1) x_rdata = t_rdata;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ack", 64'(bus.ack), 64'(x_ack));
         chk("m_mem_write", 64'(bus.mem_write), 64'(x_wr));
         chk("m_mem_read", 64'(bus.mem_read), 64'(x_rd));
         chk("m_mem_addr", bus.mem_addr, t_addr);
         chk("m_mem_wdata", bus.mem_wdata, t_wdata);
         chk("m_rdata", bus.rdata, x_rdata);
      end
   end

   task automatic single(input int p, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] exp_rd);
      @(negedge clk);
      bus.req[p] = 1'b1; bus.we[p] = w; bus.addr[p] = a; bus.wdata[p] = d;
      @(negedge clk);
      chk("acc_write", 64'(bus.mem_write), 64'(w));
      chk("acc_read", 64'(bus.mem_read), 64'(!w));
      chk("acc_addr", bus.mem_addr, a);
      chk("acc_wdata", bus.mem_wdata, d);
      chk("acc_no_ack", 64'(bus.ack), 64'd0);
      @(negedge clk);
      chk("resp_ack", 64'(bus.ack), 64'd1 << p);
      chk("resp_rdata", bus.rdata, exp_rd);
      chk("resp_strobes", {62'd0, bus.mem_write, bus.mem_read}, 64'd0);
      bus.req[p] = 1'b0;
      @(negedge clk);
      chk("ack_clear", 64'(bus.ack), 64'd0);
   endtask

   int ackq[$];
   int exp_order[4];
   int gap;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.req = 2'b00; bus.we = 2'b00; bus.addr = '0; bus.wdata = '0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ack", 64'(bus.ack), 64'd0);
      chk("rst_rdata", bus.rdata, 64'd0);
      chk("rst_mem_addr", bus.mem_addr, 64'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
      chk("rst_strobes", {62'd0, bus.mem_write, bus.mem_read}, 64'd0);
      rst_n = 1'b1;

      single(0, 1'b0, 64'd0, 64'd0, 64'h0807060504030201);
      single(1, 1'b0, 64'd60, 64'd0, 64'h04030201403F3E3D);
      single(0, 1'b1, 64'd8, 64'hA5A5_0000_0000_5A5A, 64'h04030201403F3E3D);
      single(1, 1'b0, 64'd8, 64'd0, 64'hA5A5_0000_0000_5A5A);

      // Contention: both ports request continuously for four transactions.
`ifdef DMEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      bus.we = 2'b00; bus.addr[0] = 64'd16; bus.addr[1] = 64'd24; bus.req = 2'b11;
      for (int c = 0; c < 40 && ackq.size() < 4; c++) begin
         @(negedge clk);
         if (bus.ack[0]) ackq.push_back(0);
         if (bus.ack[1]) ackq.push_back(1);
      end
      bus.req = 2'b00;
      chk("cont_count", 64'(ackq.size()), 64'd4);
      for (int i = 0; i < ackq.size() && i < 4; i++)
         chk($sformatf("cont_order%0d", i), 64'(ackq[i]), 64'(exp_order[i]));
      @(negedge clk);

      // Late loser: port 1 rises while port 0 is in ACCESS.
      @(negedge clk);
      bus.req[0] = 1'b1; bus.addr[0] = 64'd32;
      @(negedge clk);
      bus.req[1] = 1'b1; bus.addr[1] = 64'd40;
      @(negedge clk);
      chk("late_ack0", 64'(bus.ack), 64'd1);
      bus.req[0] = 1'b0;
      gap = 0;
      for (int c = 1; c <= 10 && gap == 0; c++) begin
         @(negedge clk);
         if (bus.ack[1]) gap = c;
      end
      bus.req[1] = 1'b0;
      chk("late_gap", 64'(gap), 64'd3);
      chk("late_rdata", bus.rdata, 64'h302F2E2D2C2B2A29);
      @(negedge clk);

      // Reset asserted in the middle of a write ACCESS.
      @(negedge clk);
      bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr[0] = 64'd16; bus.wdata[0] = 64'h1122334455667788;
      @(negedge clk);
      chk("rma_write_hi", 64'(bus.mem_write), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rma_write", 64'(bus.mem_write), 64'd0);
      chk("rma_ack", 64'(bus.ack), 64'd0);
      chk("rma_rdata", bus.rdata, 64'd0);
      bus.req = 2'b00; bus.we = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      single(1, 1'b0, 64'd0, 64'd0, 64'h0807060504030201);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
